// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : ALU operation codes and sequencer state encoding, shared with
//               the ALU controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] c_ALU_ADD  = 4'd0;
    localparam logic [3:0] c_ALU_SUB  = 4'd1;
    localparam logic [3:0] c_ALU_AND  = 4'd2;
    localparam logic [3:0] c_ALU_OR   = 4'd3;
    localparam logic [3:0] c_ALU_SLT  = 4'd4;
    localparam logic [3:0] c_ALU_BEQ  = 4'd5;
    localparam logic [3:0] c_ALU_SRA  = 4'd6;
    localparam logic [3:0] c_ALU_LUI  = 4'd7;
    localparam logic [3:0] c_ALU_BNE  = 4'd8;
    localparam logic [3:0] c_ALU_LUP  = 4'd9;
    localparam logic [3:0] c_ALU_SRAV = 4'd10;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == c_ALU_SRA) || (code == c_ALU_SRAV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shifter.sv
`default_nettype none
// ============================================================================
// Module      : alu_shifter
// Description : Iterative arithmetic right shifter, one bit per enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shifter #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [4:0]        amount_i,
    output logic [DATA_W-1:0] data_o,
    output logic [4:0]        count_o,
    output logic              last_o
);

    logic [DATA_W-1:0] r_data;
    logic [4:0]        r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (load_i) begin
            r_data  <= data_i;
            r_count <= amount_i;
        end else if (en_i && (r_count != 5'd0)) begin
            r_data  <= {r_data[DATA_W-1], r_data[DATA_W-1:1]};
            r_count <= r_count - 5'd1;
        end
    end

    assign data_o  = r_data;
    assign count_o = r_count;
    // High during the step that brings the remaining count to zero.
    assign last_o  = (r_count == 5'd1);

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequenced ALU; single-cycle ops plus an iterative arithmetic
//               right shift, with busy/done handshake and held results.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [3:0]        ALUCtrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [4:0]        shamt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              illegal_o
);

    import alu_pkg::*;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;
    logic              r_illegal;

    logic              w_accept;
    logic              w_is_shift;
    logic [4:0]        w_amount;
    logic              w_go_shift;
    logic              w_shift_done;

    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_zero;
    logic              w_alu_illegal;

    logic [DATA_W-1:0] w_shift_data;
    logic [4:0]        w_shift_cnt;
    logic              w_shift_last;
    logic [DATA_W-1:0] w_shift_final;

    assign w_accept   = (r_state == c_ST_IDLE) && start_i;
    assign w_is_shift = is_shift(ALUCtrl_i);
    assign w_amount   = (ALUCtrl_i == c_ALU_SRAV) ? src1_i[4:0] : shamt_i;
    assign w_go_shift = w_is_shift && (w_amount != 5'd0);

    assign w_sum  = src1_i + src2_i;
    assign w_diff = src1_i - src2_i;

    alu_shifter #(
        .DATA_W   (DATA_W)
    ) u_shifter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (w_accept && w_is_shift),
        .en_i     (r_state == c_ST_SHIFT),
        .data_i   (src2_i),
        .amount_i (w_amount),
        .data_o   (w_shift_data),
        .count_o  (w_shift_cnt),
        .last_o   (w_shift_last)
    );

    // The final step is folded into the result load so done_o lands at amount+1.
    assign w_shift_final = w_shift_last ? {w_shift_data[DATA_W-1], w_shift_data[DATA_W-1:1]}
                                        : w_shift_data;
    assign w_shift_done  = w_shift_last || (w_shift_cnt == 5'd0);

    // Single-cycle datapath evaluated on the live inputs at the accepting edge.
    always_comb begin
        w_alu_result  = '0;
        w_alu_illegal = 1'b0;
        case (ALUCtrl_i)
            c_ALU_ADD:            w_alu_result = w_sum;
            c_ALU_SUB:            w_alu_result = w_diff;
            c_ALU_AND:            w_alu_result = src1_i & src2_i;
            c_ALU_OR:             w_alu_result = src1_i | src2_i;
            c_ALU_SLT:            w_alu_result = {{(DATA_W-1){1'b0}},
                                                  ($signed(src1_i) < $signed(src2_i))};
            c_ALU_BEQ, c_ALU_BNE: w_alu_result = w_diff;
            c_ALU_SRA, c_ALU_SRAV: w_alu_result = src2_i;
            c_ALU_LUI, c_ALU_LUP: w_alu_result = DATA_W'({src2_i[15:0], 16'h0000});
            default:              w_alu_illegal = 1'b1;
        endcase
        if (w_alu_illegal)
            w_alu_zero = 1'b0;
        else if (ALUCtrl_i == c_ALU_BNE)
            w_alu_zero = (w_diff != '0);
        else
            w_alu_zero = (w_alu_result == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (start_i) w_next_state = w_go_shift ? c_ST_SHIFT : c_ST_DONE;
            c_ST_SHIFT: if (w_shift_done) w_next_state = c_ST_DONE;
            c_ST_DONE:  w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (r_state)
            c_ST_SHIFT: busy_o = 1'b1;
            c_ST_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Result flags change only on the edge that enters DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept && !w_go_shift) begin
            r_result  <= w_alu_result;
            r_zero    <= w_alu_zero;
            r_illegal <= w_alu_illegal;
        end else if ((r_state == c_ST_SHIFT) && w_shift_done) begin
            r_result  <= w_shift_final;
            r_zero    <= (w_shift_final == '0);
            r_illegal <= 1'b0;
        end
    end

    assign result_o  = r_result;
    assign zero_o    = r_zero;
    assign illegal_o = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq with a behavioural reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int DATA_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [3:0]        ALUCtrl_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic [4:0]        shamt_i;
    logic              busy_o;
    logic              done_o;
    logic [DATA_W-1:0] result_o;
    logic              zero_o;
    logic              illegal_o;

    logic [31:0] hold_result;
    logic        hold_zero;
    logic        hold_illegal;
    int          n_asserts = 0;
    int          n_fail    = 0;

    alu_seq #(
        .DATA_W    (DATA_W)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .ALUCtrl_i (ALUCtrl_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .shamt_i   (shamt_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .illegal_o (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the operation definitions.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] res,
                                  output logic z, output logic ill, output int lat);
        int amt;
        res = 32'd0;
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0:        res = a + b;
            4'd1:        res = a - b;
            4'd2:        res = a & b;
            4'd3:        res = a | b;
            4'd4:        res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5, 4'd8:  res = a - b;
            4'd6, 4'd10: begin
                amt = (op == 4'd6) ? int'(sh) : int'(a[4:0]);
                res = $signed(b) >>> amt;
                lat = amt + 1;
            end
            4'd7, 4'd9:  res = {b[15:0], 16'h0000};
            default:     ill = 1'b1;
        endcase
        if (ill)            z = 1'b0;
        else if (op == 4'd5) z = (a == b);
        else if (op == 4'd8) z = (a != b);
        else                z = (res == 32'd0);
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input bit poke);
        logic [31:0] m_res;
        logic        m_zero;
        logic        m_ill;
        int          lat;
        model(op, a, b, sh, m_res, m_zero, m_ill, lat);
        @(negedge clk_i);
        check($sformatf("%s_idle_busy", tag), 32'(busy_o), 32'd0);
        start_i   = 1'b1;
        ALUCtrl_i = op;
        src1_i    = a;
        src2_i    = b;
        shamt_i   = sh;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk_i);
            if (poke) begin
                start_i   = 1'b1;
                ALUCtrl_i = 4'($urandom_range(0, 15));
                src1_i    = $urandom;
                src2_i    = $urandom;
                shamt_i   = 5'($urandom_range(0, 31));
            end else begin
                start_i = 1'b0;
            end
            check($sformatf("%s_busy_c%0d", tag, k), 32'(busy_o), 32'd1);
            check($sformatf("%s_done_c%0d", tag, k), 32'(done_o), 32'(k == lat));
            if (k == lat) begin
                check($sformatf("%s_result", tag), result_o, m_res);
                check($sformatf("%s_zero", tag), 32'(zero_o), 32'(m_zero));
                check($sformatf("%s_illegal", tag), 32'(illegal_o), 32'(m_ill));
                hold_result  = m_res;
                hold_zero    = m_zero;
                hold_illegal = m_ill;
            end else begin
                check($sformatf("%s_hold_result_c%0d", tag, k), result_o, hold_result);
                check($sformatf("%s_hold_zero_c%0d", tag, k), 32'(zero_o), 32'(hold_zero));
                check($sformatf("%s_hold_ill_c%0d", tag, k), 32'(illegal_o), 32'(hold_illegal));
            end
        end
        @(negedge clk_i);
        check($sformatf("%s_after_busy", tag), 32'(busy_o), 32'd0);
        check($sformatf("%s_after_done", tag), 32'(done_o), 32'd0);
        start_i = 1'b0;
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic [4:0]  r_sh;

        rst_i     = 1'b1;
        start_i   = 1'b1;
        ALUCtrl_i = 4'd0;
        src1_i    = 32'd7;
        src2_i    = 32'd9;
        shamt_i   = 5'd0;
        hold_result  = 32'd0;
        hold_zero    = 1'b0;
        hold_illegal = 1'b0;

        // Reset held with start asserted: nothing may be accepted.
        repeat (3) @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_zero", 32'(zero_o), 32'd0);
        check("rst_illegal", 32'(illegal_o), 32'd0);
        start_i = 1'b0;
        rst_i   = 1'b0;

        run_op("add", 4'd0, 32'h0000_0005, 32'hFFFF_FFFD, 5'd0, 1'b0);
        check("add_lit", result_o, 32'h0000_0002);
        check("add_lit_zero", 32'(zero_o), 32'd0);

        run_op("sra", 4'd6, 32'h0, 32'h8000_0010, 5'd4, 1'b0);
        check("sra_lit", result_o, 32'hF800_0001);

        run_op("beq", 4'd5, 32'h1234, 32'h1234, 5'd0, 1'b0);
        check("beq_lit_zero", 32'(zero_o), 32'd1);
        run_op("bne", 4'd8, 32'h1234, 32'h1234, 5'd0, 1'b0);
        check("bne_lit_zero", 32'(zero_o), 32'd0);
        run_op("slt", 4'd4, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b0);
        check("slt_lit", result_o, 32'd1);

        run_op("srav_poke", 4'd10, 32'h0000_0023, 32'h8000_F000, 5'd17, 1'b1);
        check("srav_lit", result_o, 32'hF000_1E00);

        // Reset two cycles into a 20-step shift.
        @(negedge clk_i);
        start_i   = 1'b1;
        ALUCtrl_i = 4'd10;
        src1_i    = 32'd20;
        src2_i    = $urandom;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_result", result_o, 32'd0);
        check("abort_zero", 32'(zero_o), 32'd0);
        check("abort_illegal", 32'(illegal_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        hold_result  = 32'd0;
        hold_zero    = 1'b0;
        hold_illegal = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_i);
            check($sformatf("abort_quiet_c%0d", i), 32'({busy_o, done_o}), 32'd0);
        end
        run_op("add_post_rst", 4'd0, $urandom, $urandom, 5'd0, 1'b0);

        run_op("undef13", 4'd13, $urandom, $urandom, 5'd0, 1'b0);
        check("undef_lit_ill", 32'(illegal_o), 32'd1);
        check("undef_lit_res", result_o, 32'd0);
        run_op("lui", 4'd7, $urandom, 32'h0000_ABCD, 5'd0, 1'b0);
        check("lui_lit", result_o, 32'hABCD_0000);
        check("lui_lit_ill", 32'(illegal_o), 32'd0);

        for (int n = 0; n < 40; n++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? r_a : $urandom;
            r_sh = 5'($urandom_range(0, 31));
            run_op($sformatf("rnd%0d_op%0d", n, r_op), r_op, r_a, r_b, r_sh, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
